// File: rtl/relu_maxpool_pkg.sv
// Shared constants for the ReLU / max-pool stages of the garbled NN pipeline.
// Holds default widths and the {r_in, r_out} field layout of g_input.
package relu_maxpool_pkg;

    localparam int N_DEF     = 32;
    localparam int K_DEF     = 4;
    localparam int R_OUT_LSB = 0;

    // r_in sits directly above the N-bit r_out field
    function automatic int r_in_lsb(input int n);
        return n;
    endfunction

    typedef enum logic [1:0] {
        EV_IDLE,
        EV_ACCEPT,
        EV_FLUSH
    } pool_ev_e;

endpackage

// File: rtl/relu_maxpool_max.sv
// Combinational N-bit unsigned maximum.
module max_u #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    assign y = (a > b) ? a : b;

endmodule

// File: rtl/relu_maxpool.sv
// Sequential unsigned max-pool over K masked ReLU outputs.
// Unmasks each element, tracks the window max, re-masks on close.
module relu_maxpool
    import relu_maxpool_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int K  = K_DEF,
    parameter int CW = $clog2(K + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [2*N-1:0]  g_input,
    input  logic [N-1:0]    e_input,
    output logic [N-1:0]    o,
    output logic            o_valid,
    output logic [CW-1:0]   o_count
);

    localparam int R_IN_LSB = r_in_lsb(N);

    logic [N-1:0]  r_in;
    logic [N-1:0]  r_out;
    logic [N-1:0]  v;
    logic [N-1:0]  mx_v;
    logic [N-1:0]  m;
    logic          last;
    pool_ev_e      ev;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  mx_q, mx_d;
    logic [N-1:0]  o_q, o_d;
    logic          o_valid_q, o_valid_d;
    logic [CW-1:0] o_count_q, o_count_d;

    assign r_in  = g_input[R_IN_LSB +: N];
    assign r_out = g_input[R_OUT_LSB +: N];

    // e_input - r_in as e_input + ~r_in + 1, carry discarded
    assign v = e_input + ~r_in + 1'b1;

    max_u #(.N(N)) u_max (
        .a (mx_q),
        .b (v),
        .y (mx_v)
    );

    assign m    = (cnt_q == '0) ? v : mx_v;
    assign last = (cnt_q == CW'(K - 1)) || flush;

    always_comb begin
        ev = EV_IDLE;
        if (in_valid) begin
            ev = EV_ACCEPT;
        end else if (flush && cnt_q != '0) begin
            ev = EV_FLUSH;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        mx_d      = mx_q;
        o_d       = o_q;
        o_count_d = o_count_q;
        o_valid_d = 1'b0;
        unique case (ev)
            EV_ACCEPT: begin
                if (last) begin
                    o_d       = m + r_out;
                    o_count_d = cnt_q + 1'b1;
                    o_valid_d = 1'b1;
                    cnt_d     = '0;
                    mx_d      = '0;
                end else begin
                    mx_d  = m;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EV_FLUSH: begin
                o_d       = mx_q + r_out;
                o_count_d = cnt_q;
                o_valid_d = 1'b1;
                cnt_d     = '0;
                mx_d      = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            mx_q      <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            o_count_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            mx_q      <= mx_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            o_count_q <= o_count_d;
        end
    end

    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign o_count = o_count_q;

endmodule
